// File: rtl/msrv32_mdu_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit.
package msrv32_mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX} mdu_state_e;

  // Widest operand the helper below can handle; callers zero-extend into it.
  localparam int unsigned MAX_W = 128;

  // Two's-complement magnitude of a w-bit value held in the low bits of v.
  function automatic logic [MAX_W-1:0] twos_abs(input logic [MAX_W-1:0] v, input int unsigned w);
    return v[w-1] ? -v : v;
  endfunction

endpackage

// File: rtl/msrv32_mdu_step.sv
// One radix-2 iteration: shift-add multiply (LSB first) or restoring divide (MSB first).
module msrv32_mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_in,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] opb_in,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_keep;

  always_comb begin
    sum      = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opb_in} : '0);
    // Remainder stays below the divisor, so the shifted value needs only XLEN+1 bits.
    diff     = {hi_in, lo_in[XLEN-1]} - {1'b0, opb_in};
    rem_keep = {hi_in[XLEN-2:0], lo_in[XLEN-1]};
    if (is_div_in) begin
      hi_out = diff[XLEN] ? rem_keep : diff[XLEN-1:0];
      lo_out = {lo_in[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_out = sum[XLEN:1];
      lo_out = {sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/msrv32_mdu.sv
// Iterative RV32M multiply/divide unit with valid/ready accept, flush and one-cycle result pulse.
// state | meaning
// IDLE  | ready for a new operation
// CALC  | iterating, BITS_PER_CYCLE bits per edge
// FIX   | sign correction, field select, result register
module msrv32_mdu
  import msrv32_mdu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_n_in,
  input  logic            valid_in,
  input  logic            kill_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] op1_in,
  input  logic [XLEN-1:0] op2_in,
  output logic            ready_out,
  output logic            valid_out,
  output logic [XLEN-1:0] result_out
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;

  logic            signed1, signed2, sign1, sign2, div_zero, div_ovf;
  logic [MAX_W-1:0] ext1, ext2, abs1_w, abs2_w;
  logic [XLEN-1:0] mag1, mag2;
  logic            unused_abs_hi;

  always_comb begin
    signed1  = (funct3_in == F3_MULH) || (funct3_in == F3_MULHSU) ||
               (funct3_in == F3_DIV)  || (funct3_in == F3_REM);
    signed2  = (funct3_in == F3_MULH) || (funct3_in == F3_DIV) || (funct3_in == F3_REM);
    sign1    = signed1 & op1_in[XLEN-1];
    sign2    = signed2 & op2_in[XLEN-1];
    ext1     = '0;
    ext2     = '0;
    ext1[XLEN-1:0] = op1_in;
    ext2[XLEN-1:0] = op2_in;
    abs1_w   = sign1 ? twos_abs(ext1, XLEN) : ext1;
    abs2_w   = sign2 ? twos_abs(ext2, XLEN) : ext2;
    mag1     = abs1_w[XLEN-1:0];
    mag2     = abs2_w[XLEN-1:0];
    div_zero = funct3_in[2] && (op2_in == '0);
    div_ovf  = ((funct3_in == F3_DIV) || (funct3_in == F3_REM)) &&
               (op1_in == MIN_INT) && (op2_in == '1);
  end

  assign unused_abs_hi = ^{abs1_w[MAX_W-1:XLEN], abs2_w[MAX_W-1:XLEN]};

  logic [XLEN-1:0] hi_c [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] lo_c [BITS_PER_CYCLE+1];

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    msrv32_mdu_step #(.XLEN(XLEN)) u_step (
      .is_div_in (funct3_q[2]),
      .hi_in     (hi_c[i]),
      .lo_in     (lo_c[i]),
      .opb_in    (opb_q),
      .hi_out    (hi_c[i+1]),
      .lo_out    (lo_c[i+1])
    );
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = neg_res_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -hi_q : hi_q;
    case (funct3_q)
      F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    if (kill_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (valid_in) begin
          funct3_d = funct3_in;
          opb_d    = mag2;
          cnt_d    = CNT_INIT;
          // Special cases preload the final raw fields so FIX needs no sign work.
          if (div_zero) begin
            hi_d = op1_in;  lo_d = '1;  neg_res_d = 1'b0;  neg_rem_d = 1'b0;
            state_d = FIX;
          end else if (div_ovf) begin
            hi_d = '0;  lo_d = MIN_INT;  neg_res_d = 1'b0;  neg_rem_d = 1'b0;
            state_d = FIX;
          end else begin
            hi_d = '0;  lo_d = mag1;  neg_res_d = sign1 ^ sign2;  neg_rem_d = sign1;
            state_d = CALC;
          end
        end
        CALC: begin
          hi_d  = hi_c[BITS_PER_CYCLE];
          lo_d  = lo_c[BITS_PER_CYCLE];
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = FIX;
        end
        FIX: begin
          result_d = fix_res;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q   <= IDLE;
      funct3_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign ready_out  = (state_q == IDLE);
  assign valid_out  = valid_q;
  assign result_out = result_q;

endmodule

// File: tb/tb_msrv32_mdu.sv
// Randomized and directed bench for msrv32_mdu against a plain-arithmetic RV32M reference.
module tb_msrv32_mdu;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0, kill_in = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        ready, vout;
  logic [31:0] res;

  logic        valid_in2 = 1'b0, kill_in2 = 1'b0;
  logic [2:0]  funct3_2 = '0;
  logic [31:0] op1_2 = '0, op2_2 = '0;
  logic        ready2, vout2;
  logic [31:0] res2;

  always #5 clk = ~clk;

  msrv32_mdu #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .valid_in(valid_in), .kill_in(kill_in), .funct3_in(funct3),
    .op1_in(op1), .op2_in(op2),
    .ready_out(ready), .valid_out(vout), .result_out(res));

  msrv32_mdu #(.XLEN(32), .BITS_PER_CYCLE(2)) dut2 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .valid_in(valid_in2), .kill_in(kill_in2), .funct3_in(funct3_2),
    .op1_in(op1_2), .op2_in(op2_2),
    .ready_out(ready2), .valid_out(vout2), .result_out(res2));

  int n_vec = 0, n_err = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct { logic [31:0] res; int due; } exp_t;
  exp_t        expq[$];
  logic [31:0] last_res = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, ua;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f3)
      MUL:    begin p = 64'(ua * ub); return p[31:0];  end
      MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int n);
    if (f3[2] && (b == 0 || ((f3 == DIV || f3 == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return n + 1;
  endfunction

  // Scoreboard: valid_out must pulse exactly on the due edge, result_out holds otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_res = '0;
    end else if (expq.size() > 0 && expq[0].due == edge_cnt) begin
      chk("valid_pulse", 32'(vout), 32'd1);
      chk("result", res, expq[0].res);
      last_res = expq[0].res;
      void'(expq.pop_front());
    end else begin
      chk("valid_idle", 32'(vout), 32'd0);
      chk("result_hold", res, last_res);
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    funct3 = f3; op1 = a; op2 = b; valid_in = 1'b1;
    @(posedge clk); #1;
    expq.push_back('{res: model(f3, a, b), due: edge_cnt + lat(f3, a, b, 32)});
    valid_in = 1'b0;
    funct3 = 3'($urandom_range(0, 7)); op1 = $urandom; op2 = $urandom;
  endtask

  task automatic issue2(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int acc, k;
    chk("ready2", 32'(ready2), 32'd1);
    funct3_2 = f3; op1_2 = a; op2_2 = b; valid_in2 = 1'b1;
    @(posedge clk); #1;
    acc = edge_cnt;
    valid_in2 = 1'b0; op1_2 = $urandom; op2_2 = $urandom;
    k = 0;
    while (!vout2 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency2", 32'(edge_cnt - acc), 32'(lat(f3, a, b, 16)));
    chk("result2", res2, model(f3, a, b));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t dir[] = '{
    '{MUL, 32'd7, 32'hFFFF_FFFD}, '{MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{MULH, 32'h8000_0000, 32'h8000_0000}, '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{DIV, 32'hFFFF_FFF9, 32'd2}, '{REM, 32'hFFFF_FFF9, 32'd2},
    '{DIVU, 32'd100, 32'd7}, '{REMU, 32'd100, 32'd7},
    '{DIV, 32'd5, 32'd0}, '{REMU, 32'd5, 32'd0},
    '{DIV, 32'h8000_0000, 32'hFFFF_FFFF}, '{REM, 32'h8000_0000, 32'hFFFF_FFFF}
  };

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready_async", 32'(ready), 32'd1);
    chk("rst_valid_async", 32'(vout), 32'd0);
    chk("rst_result_async", res, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("model_mul", model(MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model_mulhu", model(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("model_mulh", model(MULH, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("model_mulhsu", model(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("model_div", model(DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem", model(REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_divu", model(DIVU, 32'd100, 32'd7), 32'd14);
    chk("model_remu0", model(REMU, 32'd5, 32'd0), 32'd5);
    chk("model_divovf", model(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("model_mul34", model(MUL, 32'd3, 32'd4), 32'd12);
    chk("model_lat", 32'(lat(MUL, 32'd7, 32'd3, 32)), 32'd33);

    foreach (dir[i]) issue(dir[i].f3, dir[i].a, dir[i].b);

    // Flush at the 10th CALC cycle of a divide.
    wait_ready();
    funct3 = DIV; op1 = 32'd1000; op2 = 32'd3; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill_in = 1'b1;
    @(posedge clk); #1;
    kill_in = 1'b0;
    chk("ready_after_kill", 32'(ready), 32'd1);
    issue(MUL, 32'd3, 32'd4);

    // Request together with flush must not be accepted.
    wait_ready();
    @(posedge clk); #1;
    funct3 = MUL; op1 = 32'd5; op2 = 32'd6; valid_in = 1'b1; kill_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; kill_in = 1'b0;
    chk("kill_blocks_accept", 32'(ready), 32'd1);
    repeat (36) begin @(posedge clk); #1; end

    // Flush during FIX suppresses the completion.
    funct3 = DIV; op1 = 32'd5; op2 = 32'd0; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; kill_in = 1'b1;
    chk("fix_not_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    kill_in = 1'b0;
    chk("ready_after_fix_kill", 32'(ready), 32'd1);
    repeat (3) begin @(posedge clk); #1; end

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 3) == 0) begin
        wait_ready();
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end

    // Async reset in the middle of a calculation.
    wait_ready();
    repeat (2) begin @(posedge clk); #1; end
    funct3 = DIVU; op1 = 32'd12345; op2 = 32'd17; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midcalc_rst_valid", 32'(vout), 32'd0);
    chk("midcalc_rst_result", res, 32'd0);
    chk("midcalc_rst_ready", 32'(ready), 32'd1);
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(MULHU, 32'hDEAD_BEEF, 32'h1234_5678);

    issue2(DIVU, 32'd100, 32'd7);
    issue2(DIV, 32'd5, 32'd0);
    for (int i = 0; i < 20; i++) issue2(3'($urandom_range(0, 7)), pick(), pick());

    wait_ready();
    repeat (3) begin @(posedge clk); #1; end
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
